ethernet_frame_gen: RTL and testbench
=====================================

// Module: ethernet_frame_gen
// PURPOSE
//  Builds complete IEEE 802.3 Ethernet frames as a byte stream for a MAC/PHY transmit path.
//  Frame order: preamble, SFD, dest MAC, src MAC, EtherType, payload, zero pad to 46 bytes, then the CRC-32 FCS.
//  The payload is first buffered in full from a valid/ready input.
//  The frame is then streamed on a valid/ready output with SOP/EOP markers and a completion pulse.
// PARAMETERS
//  CLK_FREQ     125_000_000  clock frequency in Hz; informational only, no logic depends on it
//  DATA_WIDTH   8            byte-lane width of payload and frame data; only 8 is supported
//  MAX_PAYLOAD  1500         payload buffer depth in bytes; also the maximum accepted payload_length
// PORTS
//  clk             in   1      single clock; all logic is on the rising edge
//  rst_n           in   1      asynchronous, active-low reset
//  start_frame     in   1      1-cycle request; header fields are sampled in the same cycle
//  dest_mac        in   48     destination MAC; bits [47:40] are sent first
//  src_mac         in   48     source MAC; bits [47:40] are sent first
//  ether_type      in   16     EtherType; bits [15:8] are sent first
//  payload_length  in   11     number of payload bytes to accept
//  payload_data    in   8      payload byte
//  payload_valid   in   1      payload byte is valid
//  payload_ready   out  1      block accepts a payload byte
//  frame_data      out  8      output frame byte
//  frame_valid     out  1      frame_data is valid
//  frame_sop       out  1      marks the first preamble byte; qualified by frame_valid
//  frame_eop       out  1      marks the last FCS byte; qualified by frame_valid
//  frame_done      out  1      1-cycle pulse when a frame has completed
//  frame_ready     in   1      downstream accepts a frame byte
// BEHAVIOUR
//  Reset: all outputs are 0, FSM is IDLE, CRC register = 0xFFFFFFFF, all counters are 0.
//  FSM states: IDLE, LOAD, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, DONE.
//  IDLE: on start_frame, latch dest_mac, src_mac, ether_type and len, then go to LOAD.
//    len = min(payload_length, MAX_PAYLOAD).
//    If len == 0, go straight to PREAMBLE instead.
//  start_frame is ignored in every state other than IDLE.
//  LOAD: payload_ready = 1 starting the cycle after start_frame.
//    Each cycle with payload_valid && payload_ready writes one byte into the buffer.
//    After the len-th byte: payload_ready drops next cycle and the FSM goes to PREAMBLE.
//    payload_valid outside LOAD is ignored.
//  Transmit handshake: a beat transfers when frame_valid && frame_ready.
//    While frame_ready = 0, frame_data, frame_sop and frame_eop hold their values.
//    frame_valid stays 1 from the first preamble byte through the last FCS byte.
//    First frame_valid occurs 1 cycle after LOAD completes.
//  Byte sequence:
//    7 x 0x55 (frame_sop on byte 0), then 0xD5.
//    6 bytes dest_mac, 6 bytes src_mac, 2 bytes ether_type.
//    len bytes from the buffer, in order.
//    If len < 46, (46 - len) bytes of 0x00.
//    4 bytes FCS, with frame_eop on the last one.
//  Total frame bytes = 26 + max(len, 46); range 72..1526.
//  FCS: CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
//    Computed over dest MAC through the last pad byte; preamble and SFD are excluded.
//    Output value = ~crc; transmitted least-significant byte first, each byte's LSB is bit 0.
//    CRC updates only on accepted beats.
//  DONE: frame_done = 1 for one cycle, on the cycle after the EOP beat is accepted; then IDLE.
//  Reset mid-frame: the frame is aborted immediately; no EOP and no done pulse are produced.
// CONFIGURATION
//  ETH_FRAME_GEN_IFG_EN
//    Defined: after DONE, the block waits 12 idle cycles (inter-frame gap) with frame_valid = 0.
//      A start_frame arriving during the gap is latched together with its header fields.
//      It is serviced when the gap ends, so no request is lost.
//    Undefined: DONE returns to IDLE immediately; there is no gap logic.
// TESTING
//  Dest FFFFFFFFFFFF, src 001122334455, type 0800, len 46, payload A5^i
//    -> 72 bytes: 55x7, D5, header, payload bytes match; SOP on byte 0, EOP on byte 71.
//  Dest 00AABBCCDDEE, type 0806, len 46, payload 5A+i
//    -> header and payload exact; FCS equals the reference CRC-32 of bytes 8..67.
//  Len 1500, alternating 0F/F0 -> 1526 bytes; EOP only on the last byte; frame_done pulses once.
//  Len 10 -> 36 x 0x00 pad bytes after the payload; 72-byte frame.
//  Len 0 -> 46 x 0x00 pad bytes; LOAD is skipped.
//  5 back-to-back frames, len 100..140, frame_ready randomly toggled
//    -> data held while stalled; all 5 frames are correct.
//  Receiver check: CRC-32 over dest..FCS yields residue 0xDEBB20E3.

Source files
------------

// File: rtl/ethernet_frame_gen.sv
// ethernet_frame_gen
// Buffers one payload from a valid/ready input, then streams a complete
// 802.3 frame (preamble, SFD, header, payload, pad, CRC-32 FCS) on a
// valid/ready byte output with SOP/EOP markers and a completion pulse.
// Optional feature macro: ETH_FRAME_GEN_IFG_EN adds a 12-cycle inter-frame
// gap after each frame; a request arriving during the gap is held and
// serviced when the gap ends.
module ethernet_frame_gen #(
    parameter int CLK_FREQ    = 125_000_000,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_frame,
    input  logic [47:0]           dest_mac,
    input  logic [47:0]           src_mac,
    input  logic [15:0]           ether_type,
    input  logic [10:0]           payload_length,
    input  logic [DATA_WIDTH-1:0] payload_data,
    input  logic                  payload_valid,
    output logic                  payload_ready,
    output logic [DATA_WIDTH-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  frame_sop,
    output logic                  frame_eop,
    output logic                  frame_done,
    input  logic                  frame_ready
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD     = 4'd1;
    localparam logic [3:0] S_PREAMBLE = 4'd2;
    localparam logic [3:0] S_SFD      = 4'd3;
    localparam logic [3:0] S_HEADER   = 4'd4;
    localparam logic [3:0] S_PAYLOAD  = 4'd5;
    localparam logic [3:0] S_PAD      = 4'd6;
    localparam logic [3:0] S_FCS      = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    localparam logic [10:0] MAX_LEN   = 11'(MAX_PAYLOAD);
    localparam logic [10:0] MIN_DATA  = 11'd46;
    localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

    // Only byte lanes, a positive clock and a buffer addressable by 11 bits are supported.
    localparam bit CFG_OK = (CLK_FREQ > 0) && (DATA_WIDTH == 8) &&
                            (MAX_PAYLOAD > 0) && (MAX_PAYLOAD <= 2047);
    generate
        if (!CFG_OK) begin : g_cfg_unsupported
        end
    endgenerate

    // Reflected CRC-32 advanced by one byte, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    logic [3:0]   state_r;
    logic [10:0]  cnt_r;
    logic [10:0]  len_r;
    logic [111:0] hdr_r;
    logic [31:0]  crc_r;
    logic         crc_en_r;
    logic         payload_ready_r;
    logic [7:0]   frame_data_r;
    logic         frame_valid_r;
    logic         frame_sop_r;
    logic         frame_eop_r;
    logic         frame_done_r;
    logic [7:0]   mem_r [0:MAX_PAYLOAD-1];
`ifdef ETH_FRAME_GEN_IFG_EN
    logic [3:0]   gap_cnt_r;
    logic         pend_r;
`endif

    logic         xfer_s;
    logic         load_s;
    logic [31:0]  crc_upd_s;
    logic [31:0]  fcs_shift_s;
    logic [111:0] hdr_shift_s;
    logic [10:0]  len_in_s;
    logic         last_pay_s;
    logic         go_s;
    logic [10:0]  go_len_s;
    logic         wr_s;

    // Handshake qualifiers, running CRC and the next header/FCS byte selectors.
    always_comb begin
        xfer_s = frame_valid_r & frame_ready;
        load_s = ~frame_valid_r | frame_ready;
        if (xfer_s && crc_en_r) begin
            crc_upd_s = crc32_byte(crc_r, frame_data_r);
        end else begin
            crc_upd_s = crc_r;
        end
        fcs_shift_s = (~crc_upd_s) >> {cnt_r[1:0], 3'b000};
        hdr_shift_s = hdr_r >> {4'd13 - cnt_r[3:0], 3'b000};
        if (payload_length > MAX_LEN) begin
            len_in_s = MAX_LEN;
        end else begin
            len_in_s = payload_length;
        end
        last_pay_s = (cnt_r == (len_r - 11'd1));
        wr_s       = (state_r == S_LOAD) && payload_valid && payload_ready_r;
`ifdef ETH_FRAME_GEN_IFG_EN
        go_s = (gap_cnt_r == 4'd0) && (start_frame || pend_r);
        if (start_frame) begin
            go_len_s = len_in_s;
        end else begin
            go_len_s = len_r;
        end
`else
        go_s     = start_frame;
        go_len_s = len_in_s;
`endif
    end

    // Payload buffer write port.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[cnt_r] <= payload_data;
        end
    end

    // Frame sequencer: request capture, payload load and byte-by-byte transmit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= S_IDLE;
            cnt_r           <= 11'd0;
            len_r           <= 11'd0;
            hdr_r           <= 112'd0;
            crc_r           <= CRC_INIT;
            crc_en_r        <= 1'b0;
            payload_ready_r <= 1'b0;
            frame_data_r    <= 8'd0;
            frame_valid_r   <= 1'b0;
            frame_sop_r     <= 1'b0;
            frame_eop_r     <= 1'b0;
            frame_done_r    <= 1'b0;
`ifdef ETH_FRAME_GEN_IFG_EN
            gap_cnt_r       <= 4'd0;
            pend_r          <= 1'b0;
`endif
        end else begin
            frame_done_r <= 1'b0;
            crc_r        <= crc_upd_s;
            case (state_r)
                S_IDLE: begin
                    if (start_frame) begin
                        hdr_r <= {dest_mac, src_mac, ether_type};
                        len_r <= len_in_s;
                    end
                    if (go_s) begin
                        state_r         <= (go_len_s == 11'd0) ? S_PREAMBLE : S_LOAD;
                        payload_ready_r <= (go_len_s != 11'd0);
                        cnt_r           <= 11'd0;
                        crc_r           <= CRC_INIT;
                        crc_en_r        <= 1'b0;
                    end
`ifdef ETH_FRAME_GEN_IFG_EN
                    if (gap_cnt_r != 4'd0) begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                        pend_r    <= pend_r | start_frame;
                    end else begin
                        pend_r    <= 1'b0;
                    end
`endif
                end
                S_LOAD: begin
                    if (payload_valid && payload_ready_r) begin
                        if (last_pay_s) begin
                            payload_ready_r <= 1'b0;
                            state_r         <= S_PREAMBLE;
                            cnt_r           <= 11'd0;
                        end else begin
                            cnt_r <= cnt_r + 11'd1;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (load_s) begin
                        frame_valid_r <= 1'b1;
                        frame_data_r  <= 8'h55;
                        frame_sop_r   <= (cnt_r == 11'd0);
                        frame_eop_r   <= 1'b0;
                        crc_en_r      <= 1'b0;
                        if (cnt_r == 11'd6) begin
                            state_r <= S_SFD;
                            cnt_r   <= 11'd0;
                        end else begin
                            cnt_r <= cnt_r + 11'd1;
                        end
                    end
                end
                S_SFD: begin
                    if (load_s) begin
                        frame_data_r <= 8'hD5;
                        frame_sop_r  <= 1'b0;
                        crc_en_r     <= 1'b0;
                        state_r      <= S_HEADER;
                        cnt_r        <= 11'd0;
                    end
                end
                S_HEADER: begin
                    if (load_s) begin
                        frame_data_r <= hdr_shift_s[7:0];
                        crc_en_r     <= 1'b1;
                        if (cnt_r == 11'd13) begin
                            state_r <= (len_r == 11'd0) ? S_PAD : S_PAYLOAD;
                            cnt_r   <= 11'd0;
                        end else begin
                            cnt_r <= cnt_r + 11'd1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (load_s) begin
                        frame_data_r <= mem_r[cnt_r];
                        crc_en_r     <= 1'b1;
                        if (last_pay_s) begin
                            if (len_r < MIN_DATA) begin
                                state_r <= S_PAD;
                                cnt_r   <= cnt_r + 11'd1;
                            end else begin
                                state_r <= S_FCS;
                                cnt_r   <= 11'd0;
                            end
                        end else begin
                            cnt_r <= cnt_r + 11'd1;
                        end
                    end
                end
                S_PAD: begin
                    // cnt_r counts payload plus pad bytes so padding stops at 46.
                    if (load_s) begin
                        frame_data_r <= 8'h00;
                        crc_en_r     <= 1'b1;
                        if (cnt_r == (MIN_DATA - 11'd1)) begin
                            state_r <= S_FCS;
                            cnt_r   <= 11'd0;
                        end else begin
                            cnt_r <= cnt_r + 11'd1;
                        end
                    end
                end
                S_FCS: begin
                    // cnt_r == 4 means the EOP byte is loaded and awaits acceptance.
                    if (cnt_r[2]) begin
                        if (xfer_s) begin
                            frame_valid_r <= 1'b0;
                            frame_eop_r   <= 1'b0;
                            frame_data_r  <= 8'h00;
                            frame_done_r  <= 1'b1;
                            state_r       <= S_DONE;
                            cnt_r         <= 11'd0;
                        end
                    end else if (load_s) begin
                        frame_data_r <= fcs_shift_s[7:0];
                        crc_en_r     <= 1'b0;
                        frame_eop_r  <= (cnt_r[1:0] == 2'd3);
                        cnt_r        <= cnt_r + 11'd1;
                    end
                end
                S_DONE: begin
`ifdef ETH_FRAME_GEN_IFG_EN
                    gap_cnt_r <= 4'd12;
`endif
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign payload_ready = payload_ready_r;
    assign frame_data    = frame_data_r;
    assign frame_valid   = frame_valid_r;
    assign frame_sop     = frame_sop_r;
    assign frame_eop     = frame_eop_r;
    assign frame_done    = frame_done_r;

endmodule

// File: tb/tb_ethernet_frame_gen.sv
// tb_ethernet_frame_gen
// Randomized bench: builds each expected frame from the header, payload,
// padding rule and a bit-serial CRC-32, then compares the streamed bytes,
// markers, stall behaviour and done pulse.
module tb_ethernet_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_frame;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] ether_type;
    logic [10:0] payload_length;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic        payload_ready;
    logic [7:0]  frame_data;
    logic        frame_valid;
    logic        frame_sop;
    logic        frame_eop;
    logic        frame_done;
    logic        frame_ready;

    int checks = 0;
    int errors = 0;
    logic [7:0] pay [0:2047];

    always #5 clk = ~clk;

    ethernet_frame_gen dut (
        .clk(clk), .rst_n(rst_n), .start_frame(start_frame),
        .dest_mac(dest_mac), .src_mac(src_mac), .ether_type(ether_type),
        .payload_length(payload_length), .payload_data(payload_data),
        .payload_valid(payload_valid), .payload_ready(payload_ready),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_sop(frame_sop), .frame_eop(frame_eop),
        .frame_done(frame_done), .frame_ready(frame_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit-serial CRC-32 register (no final inversion) over q[from..end].
    function automatic logic [31:0] crc_reg_of(input logic [7:0] q [$], input int from);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = from; i < q.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    // Issue a request and push the (clamped) payload with random valid gaps.
    task automatic request_and_feed(input logic [47:0] d, input logic [47:0] s,
                                    input logic [15:0] t, input int plen, input string name);
        int len;
        int idx;
        int budget;
        len = (plen > 1500) ? 1500 : plen;
        @(negedge clk);
        dest_mac = d; src_mac = s; ether_type = t;
        payload_length = plen[10:0];
        start_frame = 1'b1;
        @(negedge clk);
        start_frame = 1'b0;
        dest_mac = {16'($urandom), $urandom};
        src_mac  = {16'($urandom), $urandom};
        ether_type = 16'($urandom);
        payload_length = 11'($urandom);
        idx = 0;
        budget = 0;
        while (idx < len && budget < 20000) begin
            payload_valid = ($urandom_range(0, 3) != 0);
            payload_data  = pay[idx];
            #1;
            if (payload_valid && payload_ready) idx++;
            @(negedge clk);
            budget++;
        end
        payload_valid = 1'b0;
        check_eq({name, " feed_count"}, idx, len);
        #1;
        check_eq({name, " ready_drop"}, {31'd0, payload_ready}, 32'd0);
    endtask

    task automatic run_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                             input int plen, input int stall_pct, input bit poke, input string name);
        logic [7:0]  exp [$];
        logic [7:0]  got [$];
        logic [31:0] fcs;
        logic [9:0]  held;
        int len, budget, sops, sop_pos, eops, eop_pos, dones, drops, extra;
        bit eop_seen, hold_pending, started;
        len = (plen > 1500) ? 1500 : plen;
        for (int i = 0; i < 7; i++) exp.push_back(8'h55);
        exp.push_back(8'hD5);
        for (int i = 0; i < 6; i++) exp.push_back(d[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) exp.push_back(s[47 - 8*i -: 8]);
        exp.push_back(t[15:8]);
        exp.push_back(t[7:0]);
        for (int i = 0; i < len; i++) exp.push_back(pay[i]);
        for (int i = len; i < 46; i++) exp.push_back(8'h00);
        fcs = ~crc_reg_of(exp, 8);
        for (int i = 0; i < 4; i++) exp.push_back(fcs[8*i +: 8]);

        request_and_feed(d, s, t, plen, name);

        budget = 0; sops = 0; sop_pos = -1; eops = 0; eop_pos = -1; dones = 0; drops = 0;
        eop_seen = 1'b0; hold_pending = 1'b0; started = 1'b0; held = 10'd0;
        while (!eop_seen && budget < 20000) begin
            frame_ready = ($urandom_range(0, 99) >= stall_pct);
            start_frame = poke && (got.size() == 20);
            #1;
            if (hold_pending) begin
                check_eq({name, " hold"}, {22'd0, frame_data, frame_sop, frame_eop}, {22'd0, held});
            end
            if (started && !frame_valid) drops++;
            if (frame_valid) started = 1'b1;
            if (frame_done) dones++;
            if (frame_valid && frame_ready) begin
                got.push_back(frame_data);
                if (frame_sop) begin sops++; sop_pos = got.size() - 1; end
                if (frame_eop) begin eops++; eop_pos = got.size() - 1; eop_seen = 1'b1; end
                hold_pending = 1'b0;
            end else if (frame_valid) begin
                hold_pending = 1'b1;
                held = {frame_data, frame_sop, frame_eop};
            end else begin
                hold_pending = 1'b0;
            end
            @(negedge clk);
            budget++;
        end
        start_frame = 1'b0;
        frame_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (frame_done) dones++;
            if (frame_valid) extra++;
            @(negedge clk);
        end
        check_eq({name, " eop_seen"}, {31'd0, eop_seen}, 32'd1);
        check_eq({name, " length"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check_eq($sformatf("%s byte%0d", name, i), {24'd0, got[i]}, {24'd0, exp[i]});
        end
        check_eq({name, " sop_count"}, sops, 1);
        check_eq({name, " sop_pos"}, sop_pos, 0);
        check_eq({name, " eop_count"}, eops, 1);
        check_eq({name, " eop_pos"}, eop_pos, exp.size() - 1);
        check_eq({name, " done_pulses"}, dones, 1);
        check_eq({name, " valid_gap"}, drops, 0);
        check_eq({name, " valid_after"}, extra, 0);
        if (got.size() >= 12) begin
            check_eq({name, " residue"}, crc_reg_of(got, 8), 32'hDEBB_20E3);
        end
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start_frame = 1'b0; dest_mac = 48'd0; src_mac = 48'd0;
        ether_type = 16'd0; payload_length = 11'd0; payload_data = 8'd0;
        payload_valid = 1'b0; frame_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst frame_valid", {31'd0, frame_valid}, 32'd0);
        check_eq("rst frame_sop", {31'd0, frame_sop}, 32'd0);
        check_eq("rst frame_eop", {31'd0, frame_eop}, 32'd0);
        check_eq("rst frame_done", {31'd0, frame_done}, 32'd0);
        check_eq("rst frame_data", {24'd0, frame_data}, 32'd0);
        check_eq("rst payload_ready", {31'd0, payload_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 46; i++) pay[i] = 8'hA5 ^ 8'(i);
        run_frame(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 46, 0, 1'b0, "bcast46");

        for (int i = 0; i < 46; i++) pay[i] = 8'h5A + 8'(i);
        run_frame(48'h00AA_BBCC_DDEE, {16'($urandom), $urandom}, 16'h0806, 46, 30, 1'b0, "arp46");

        for (int i = 0; i < 1500; i++) pay[i] = i[0] ? 8'hF0 : 8'h0F;
        run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h86DD, 1500, 20, 1'b0, "max1500");

        for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
        run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h0800, 10, 25, 1'b0, "pad10");

        run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h88B5, 0, 25, 1'b0, "len0");

        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 140; i++) pay[i] = 8'($urandom);
            run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'($urandom),
                      100 + 10 * f, 50, (f == 2), $sformatf("b2b%0d", f));
        end

        for (int i = 0; i < 1500; i++) pay[i] = 8'($urandom);
        run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h0800, 2000, 10, 1'b0, "clamp");

        run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h0800, 45, 20, 1'b0, "len45");
        run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h0800, 47, 20, 1'b0, "len47");
        run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h0800, 1, 20, 1'b0, "len1");

        // Abort mid-transmit with reset: outputs clear at once and no done pulse follows.
        request_and_feed({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h0800, 60, "abort");
        frame_ready = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort valid", {31'd0, frame_valid}, 32'd0);
        check_eq("abort eop", {31'd0, frame_eop}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (frame_done || frame_valid) dones++;
            @(negedge clk);
        end
        check_eq("abort quiet", dones, 0);
        for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
        run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h0800, 64, 30, 1'b0, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
